// File: rtl/ifetch_miss_queue_pkg.sv
// Shared types for the ifetch miss queue.
// THREADS is the per-core hardware thread count.
package ifetch_miss_queue_pkg;

  localparam int THREADS = 4;
  localparam int ENTRY_IDX_W = $clog2(THREADS);
  localparam int CACHE_LINE_W = 26;

  typedef logic [CACHE_LINE_W-1:0] cache_line_index_t;
  typedef logic [ENTRY_IDX_W-1:0] local_thread_idx_t;
  typedef logic [ENTRY_IDX_W-1:0] imq_entry_idx_t;
  typedef logic [THREADS-1:0] thread_bitmap_t;

  typedef enum logic [1:0] {
    IMQ_FREE,
    IMQ_WAIT_ISSUE,
    IMQ_WAIT_RESPONSE
  } imq_state_t;

  typedef struct packed {
    imq_state_t        state;
    cache_line_index_t paddr;
    thread_bitmap_t    thread_bitmap;
  } imq_entry_t;

  function automatic thread_bitmap_t thread_onehot(
    input local_thread_idx_t t
  );
    return thread_bitmap_t'(1) << t;
  endfunction

endpackage

// File: rtl/ifetch_miss_queue_rr_arbiter.sv
// Round-robin arbiter; the pointer only moves past the
// granted requester when the update strobe fires.
module rr_arbiter #(
  parameter int NUM_REQUESTERS = 4,
  localparam int IDX_W = $clog2(NUM_REQUESTERS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQUESTERS-1:0] request,
  input  logic                      update,
  input  logic [IDX_W-1:0]          update_idx,
  output logic                      grant_valid,
  output logic [IDX_W-1:0]          grant_idx
);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] start;
  logic [IDX_W-1:0] cand;

  // Search from the slot after an accepted grant in the same cycle.
  always_comb begin
    start = update ? update_idx + 1'b1 : ptr;
  end

  // First requester at or after the start position, wrapping.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      cand = start + IDX_W'(i);
      if (!grant_valid && request[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Pointer advances past the winner on acceptance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (update) begin
      ptr <= update_idx + 1'b1;
    end
  end

endmodule

// File: rtl/ifetch_miss_queue.sv
// I-cache miss queue: merges per-thread misses by line, issues
// fills round-robin, pulses wake bitmaps. Option: IFETCH_MISS_QUEUE_ECC_REFETCH_EN.
module ifetch_miss_queue
  import ifetch_miss_queue_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ifd_cache_miss,
  input  logic [CACHE_LINE_W-1:0] ifd_cache_miss_paddr,
  input  logic [ENTRY_IDX_W-1:0]  ifd_cache_miss_thread_idx,
  input  logic                    ifd_ecc_error,
  input  logic [CACHE_LINE_W-1:0] ifd_ecc_paddr,
  output logic                    imq_request_valid,
  output logic [CACHE_LINE_W-1:0] imq_request_paddr,
  output logic [ENTRY_IDX_W-1:0]  imq_request_id,
  input  logic                    l2i_request_ack,
  input  logic                    l2i_response_valid,
  input  logic [ENTRY_IDX_W-1:0]  l2i_response_id,
  output logic [THREADS-1:0]      imq_wake_bitmap,
  output logic [ENTRY_IDX_W:0]    imq_pending_count
);

  imq_entry_t [THREADS-1:0] ent;
  imq_entry_t [THREADS-1:0] ent_nxt;

  logic              ecc_req;
  cache_line_index_t ecc_line;

`ifdef IFETCH_MISS_QUEUE_ECC_REFETCH_EN
  assign ecc_req  = ifd_ecc_error;
  assign ecc_line = ifd_ecc_paddr;
`else
  logic unused_ecc;
  assign unused_ecc = ^{ifd_ecc_error, ifd_ecc_paddr};
  assign ecc_req    = 1'b0;
  assign ecc_line   = '0;
`endif

  logic           miss_hit;
  logic           ecc_hit;
  logic           any_free;
  imq_entry_idx_t miss_hit_idx;
  imq_entry_idx_t ecc_hit_idx;
  imq_entry_idx_t free_idx;
  thread_bitmap_t busy_threads;

  // Line match against pending entries and lowest free slot.
  always_comb begin
    miss_hit     = 1'b0;
    ecc_hit      = 1'b0;
    any_free     = 1'b0;
    miss_hit_idx = '0;
    ecc_hit_idx  = '0;
    free_idx     = '0;
    busy_threads = '0;
    for (int i = THREADS - 1; i >= 0; i--) begin
      if (ent[i].state == IMQ_FREE) begin
        any_free = 1'b1;
        free_idx = imq_entry_idx_t'(i);
      end else begin
        busy_threads = busy_threads | ent[i].thread_bitmap;
        if (ent[i].paddr == ifd_cache_miss_paddr) begin
          miss_hit     = 1'b1;
          miss_hit_idx = imq_entry_idx_t'(i);
        end
        if (ent[i].paddr == ecc_line) begin
          ecc_hit     = 1'b1;
          ecc_hit_idx = imq_entry_idx_t'(i);
        end
      end
    end
  end

  logic miss_alloc;
  logic ecc_alloc;
  logic ack_fire;
  logic rsp_hit;

  assign miss_alloc = ifd_cache_miss && !miss_hit;
  assign ecc_alloc  = ecc_req && !miss_alloc
                   && !ecc_hit && any_free;
  assign ack_fire   = imq_request_valid && l2i_request_ack;
  assign rsp_hit    = l2i_response_valid
                   && ent[l2i_response_id].state
                      == IMQ_WAIT_RESPONSE;

  thread_bitmap_t wake_nxt;

  // Entry updates; merges land before the wake capture so a
  // thread joining a completing fill is woken with it.
  always_comb begin
    ent_nxt  = ent;
    wake_nxt = '0;
    if (ack_fire) begin
      ent_nxt[imq_request_id].state = IMQ_WAIT_RESPONSE;
    end
    if (ifd_cache_miss && miss_hit) begin
      ent_nxt[miss_hit_idx].thread_bitmap =
        ent[miss_hit_idx].thread_bitmap
        | thread_onehot(ifd_cache_miss_thread_idx);
    end
    if (miss_alloc && any_free) begin
      ent_nxt[free_idx] = '{
        state:         IMQ_WAIT_ISSUE,
        paddr:         ifd_cache_miss_paddr,
        thread_bitmap: thread_onehot(ifd_cache_miss_thread_idx)
      };
    end
    if (ecc_alloc) begin
      ent_nxt[free_idx] = '{
        state:         IMQ_WAIT_ISSUE,
        paddr:         ecc_line,
        thread_bitmap: '0
      };
    end
    if (rsp_hit) begin
      wake_nxt = ent_nxt[l2i_response_id].thread_bitmap;
      ent_nxt[l2i_response_id].state = IMQ_FREE;
    end
  end

  logic [ENTRY_IDX_W:0] count_nxt;
  logic [THREADS-1:0]   issue_req;

  // Occupancy and issue eligibility of the next state.
  always_comb begin
    count_nxt = '0;
    issue_req = '0;
    for (int i = 0; i < THREADS; i++) begin
      if (ent_nxt[i].state != IMQ_FREE) begin
        count_nxt = count_nxt + 1'b1;
      end
      issue_req[i] = ent_nxt[i].state == IMQ_WAIT_ISSUE;
    end
  end

  logic           grant_valid;
  imq_entry_idx_t grant_idx;

  rr_arbiter #(
    .NUM_REQUESTERS(THREADS)
  ) u_arb (
    .clk        (clk),
    .reset      (reset),
    .request    (issue_req),
    .update     (ack_fire),
    .update_idx (imq_request_id),
    .grant_valid(grant_valid),
    .grant_idx  (grant_idx)
  );

  // Entry array, wake pulse, count and the held request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ent               <= '0;
      imq_wake_bitmap   <= '0;
      imq_pending_count <= '0;
      imq_request_valid <= 1'b0;
      imq_request_paddr <= '0;
      imq_request_id    <= '0;
    end else begin
      ent               <= ent_nxt;
      imq_wake_bitmap   <= wake_nxt;
      imq_pending_count <= count_nxt;
      if (!imq_request_valid || l2i_request_ack) begin
        imq_request_valid <= grant_valid;
        if (grant_valid) begin
          imq_request_paddr <= ent_nxt[grant_idx].paddr;
          imq_request_id    <= grant_idx;
        end
      end
    end
  end

  // Flag stimulus the queue cannot legally receive.
  always_ff @(posedge clk) begin
    if (reset) begin
      assert (!(miss_alloc && !any_free))
        else $error("imq: allocation with no free entry");
      assert (!(ifd_cache_miss
                && (busy_threads
                    & thread_onehot(ifd_cache_miss_thread_idx))
                   != '0))
        else $error("imq: duplicate miss from waiting thread");
      assert (!(l2i_response_valid
                && ent[l2i_response_id].state == IMQ_WAIT_ISSUE))
        else $error("imq: response to unissued entry");
    end
  end

endmodule

// File: tb/tb_ifetch_miss_queue.sv
// Directed bench for ifetch_miss_queue with a per-cycle
// line/thread model and literal spot checks.
module tb_ifetch_miss_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        miss;
  logic [25:0] mpaddr;
  logic [1:0]  mthr;
  logic        ecc;
  logic [25:0] ecc_paddr;
  logic        valid;
  logic [25:0] paddr;
  logic [1:0]  id;
  logic        ack;
  logic        rsp;
  logic [1:0]  rid;
  logic [3:0]  wake;
  logic [2:0]  count;

  always #5 clk = ~clk;

  ifetch_miss_queue dut (
    .clk                      (clk),
    .reset                    (reset),
    .ifd_cache_miss           (miss),
    .ifd_cache_miss_paddr     (mpaddr),
    .ifd_cache_miss_thread_idx(mthr),
    .ifd_ecc_error            (ecc),
    .ifd_ecc_paddr            (ecc_paddr),
    .imq_request_valid        (valid),
    .imq_request_paddr        (paddr),
    .imq_request_id           (id),
    .l2i_request_ack          (ack),
    .l2i_response_valid       (rsp),
    .l2i_response_id          (rid),
    .imq_wake_bitmap          (wake),
    .imq_pending_count        (count)
  );

  int checks = 0;
  int passes = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
  endtask

  // Model: which lines are outstanding, for whom, and
  // whether L2 has taken each one.
  logic [25:0] m_line [4];
  bit          m_busy [4];
  bit          m_issued [4];
  logic [3:0]  m_thr [4];
  logic [3:0]  exp_wake;
  int          exp_count;
  bit          sv_valid;
  logic [25:0] sv_paddr;
  logic [1:0]  sv_id;
  bit          last_ack;
  bit          checking = 1'b0;
  int          hit, fr, ehit;
  bit          alloc;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        m_busy[i] = 0; m_issued[i] = 0;
        m_thr[i] = '0; m_line[i] = '0;
      end
      exp_wake = '0; exp_count = 0;
      sv_valid = 0; last_ack = 0;
    end else begin
      exp_wake = '0;
      last_ack = ack;
      if (sv_valid && ack) m_issued[sv_id] = 1;
      hit = -1; fr = -1; ehit = -1; alloc = 0;
      for (int i = 3; i >= 0; i--) begin
        if (!m_busy[i]) fr = i;
        else begin
          if (m_line[i] == mpaddr) hit = i;
          if (m_line[i] == ecc_paddr) ehit = i;
        end
      end
      if (miss) begin
        if (hit >= 0) m_thr[hit] = m_thr[hit] | (4'd1 << mthr);
        else if (fr >= 0) begin
          alloc = 1;
          m_busy[fr] = 1; m_issued[fr] = 0;
          m_line[fr] = mpaddr; m_thr[fr] = 4'd1 << mthr;
        end
      end
`ifdef IFETCH_MISS_QUEUE_ECC_REFETCH_EN
      if (ecc && !alloc && ehit < 0 && fr >= 0) begin
        m_busy[fr] = 1; m_issued[fr] = 0;
        m_line[fr] = ecc_paddr; m_thr[fr] = '0;
      end
`endif
      if (rsp && m_busy[rid] && m_issued[rid]) begin
        exp_wake = m_thr[rid];
        m_busy[rid] = 0;
      end
      exp_count = 0;
      for (int i = 0; i < 4; i++) exp_count += int'(m_busy[i]);
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (reset) begin
      if (checking) begin
        check("pending_count", 32'(count), exp_count);
        check("wake", 32'(wake), 32'(exp_wake));
        if (sv_valid && !last_ack) begin
          check("hold_valid", 32'(valid), 1);
          check("hold_paddr", 32'(paddr), 32'(sv_paddr));
          check("hold_id", 32'(id), 32'(sv_id));
        end
        if (valid) begin
          check("req_pending",
                32'(m_busy[id] && !m_issued[id]), 1);
          check("req_line", 32'(paddr), 32'(m_line[id]));
        end
      end
      sv_valid = valid;
      sv_paddr = paddr;
      sv_id    = id;
    end
  end

  task automatic idle();
    miss = 0; mpaddr = '0; mthr = '0;
    ecc = 0; ecc_paddr = '0;
    ack = 0; rsp = 0; rid = '0;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_miss(input int t, input logic [25:0] a);
    miss = 1; mthr = 2'(t); mpaddr = a;
  endtask

  initial begin
    idle();
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(valid), 0);
    check("rst_count", 32'(count), 0);
    check("rst_wake", 32'(wake), 0);
    reset = 1; checking = 1;

    // single miss, issue, fill
    do_miss(1, 26'h0001234); tick(); idle();
    check("t1_valid", 32'(valid), 1);
    check("t1_paddr", 32'(paddr), 32'h1234);
    check("t1_id", 32'(id), 0);
    check("t1_count", 32'(count), 1);
    ack = 1; tick(); idle();
    check("t1_drop", 32'(valid), 0);
    rsp = 1; rid = 0; tick(); idle();
    check("t1_wake", 32'(wake), 32'b0010);
    check("t1_count0", 32'(count), 0);
    tick();
    check("t1_pulse", 32'(wake), 0);

    // two threads, one line
    do_miss(0, 26'h0000ABC); tick(); idle();
    check("t2_id", 32'(id), 0);
    check("t2_paddr", 32'(paddr), 32'hABC);
    do_miss(2, 26'h0000ABC); ack = 1; tick(); idle();
    check("t2_single", 32'(valid), 0);
    check("t2_count", 32'(count), 1);
    rsp = 1; rid = 0; tick(); idle();
    check("t2_wake", 32'(wake), 32'b0101);
    tick();

    // four misses, ack held off, then drained in order
    for (int t = 0; t < 4; t++) begin
      do_miss(t, 26'(32'h10 + t)); tick(); idle();
      check("t3_hold_paddr", 32'(paddr), 32'h10);
      check("t3_hold_id", 32'(id), 0);
    end
    tick(); tick();
    check("t3_stable", 32'(paddr), 32'h10);
    check("t3_count", 32'(count), 4);
    for (int k = 0; k < 4; k++) begin
      check("t3_valid", 32'(valid), 1);
      check("t3_order", 32'(id), k);
      ack = 1; tick(); idle();
    end
    check("t3_done", 32'(valid), 0);
    for (int k = 0; k < 4; k++) begin
      rsp = 1; rid = 2'(k); tick(); idle();
      check("t3_wake", 32'(wake), 32'(1) << k);
      check("t3_cnt", 32'(count), 3 - k);
    end
    tick();

    // merge into a completing fill
    do_miss(0, 26'h55); tick(); idle();
    check("t4_id", 32'(id), 0);
    ack = 1; tick(); idle();
    rsp = 1; rid = 0; do_miss(3, 26'h55); tick(); idle();
    check("t4_wake", 32'(wake), 32'b1001);
    check("t4_noreq", 32'(valid), 0);
    check("t4_count", 32'(count), 0);
    tick();

    // reset with two fills outstanding
    do_miss(0, 26'hA0); tick(); idle();
    ack = 1; do_miss(1, 26'hA1); tick(); idle();
    check("t5_id1", 32'(id), 1);
    ack = 1; tick(); idle();
    check("t5_count", 32'(count), 2);
    @(posedge clk); #2 reset = 0; #1;
    check("t5_rst_valid", 32'(valid), 0);
    check("t5_rst_paddr", 32'(paddr), 0);
    check("t5_rst_id", 32'(id), 0);
    check("t5_rst_wake", 32'(wake), 0);
    check("t5_rst_count", 32'(count), 0);
    @(negedge clk); reset = 1;
    rsp = 1; rid = 0; tick(); idle();
    check("t5_nowake0", 32'(wake), 0);
    rsp = 1; rid = 1; tick(); idle();
    check("t5_nowake1", 32'(wake), 0);
    check("t5_cnt0", 32'(count), 0);
    tick();

    // parity refetch
    ecc = 1; ecc_paddr = 26'h77; tick(); idle();
`ifdef IFETCH_MISS_QUEUE_ECC_REFETCH_EN
    check("t6_valid", 32'(valid), 1);
    check("t6_paddr", 32'(paddr), 32'h77);
    check("t6_count", 32'(count), 1);
    ack = 1; tick(); idle();
    rsp = 1; rid = id; tick(); idle();
    check("t6_wake", 32'(wake), 0);
    check("t6_cnt0", 32'(count), 0);
`else
    check("t6_noreq", 32'(valid), 0);
    check("t6_count", 32'(count), 0);
`endif
    tick(); tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
